// File: rtl/alarm_clock_ctrl_if.sv
// Button pulses and current time into the alarm clock mode controller;
// mode, field select, counter strobes and alarm registers back out.
interface alarm_clock_ctrl_if;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       center;
  logic [4:0] cur_hr;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic       adjust;
  logic [1:0] field;
  logic       hr_inc;
  logic       hr_dec;
  logic       min_inc;
  logic       min_dec;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic       alarm_en;
  logic       ringing;

  modport master (
    output up, down, left, right, center, cur_hr, cur_min, cur_sec,
    input  adjust, field, hr_inc, hr_dec, min_inc, min_dec,
           alarm_hr, alarm_min, alarm_en, ringing
  );

  modport slave (
    input  up, down, left, right, center, cur_hr, cur_min, cur_sec,
    output adjust, field, hr_inc, hr_dec, min_inc, min_dec,
           alarm_hr, alarm_min, alarm_en, ringing
  );
endinterface

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock mode controller: RUN/ADJ/RING sequencing, alarm registers, time strobes.
// One button acted on per cycle; every effect and strobe appears one cycle later.
module alarm_clock_ctrl #(
  parameter int ALARM_HR_RST  = 0,
  parameter int ALARM_MIN_RST = 0
) (
  input logic                clk,
  input logic                rst,
  alarm_clock_ctrl_if.slave  ctrl_if
);

  typedef enum logic [1:0] {S_RUN, S_ADJ, S_RING} state_t;

  state_t     state_q, state_d;
  logic [1:0] field_q, field_d;
  logic [4:0] alarm_hr_q, alarm_hr_d;
  logic [5:0] alarm_min_q, alarm_min_d;
  logic       alarm_en_q, alarm_en_d;
  logic       adjust_q, adjust_d;
  logic       ringing_q, ringing_d;
  logic       hr_inc_q, hr_inc_d;
  logic       hr_dec_q, hr_dec_d;
  logic       min_inc_q, min_inc_d;
  logic       min_dec_q, min_dec_d;

  logic any_btn;
  logic alarm_match;

  assign any_btn = ctrl_if.center | ctrl_if.left | ctrl_if.right | ctrl_if.up | ctrl_if.down;
  assign alarm_match = alarm_en_q && (ctrl_if.cur_hr == alarm_hr_q) &&
                       (ctrl_if.cur_min == alarm_min_q) && (ctrl_if.cur_sec == 6'd0);

  always_comb begin
    state_d     = state_q;
    field_d     = field_q;
    alarm_hr_d  = alarm_hr_q;
    alarm_min_d = alarm_min_q;
    alarm_en_d  = alarm_en_q;
    hr_inc_d    = 1'b0;
    hr_dec_d    = 1'b0;
    min_inc_d   = 1'b0;
    min_dec_d   = 1'b0;

    case (state_q)
      S_RUN: begin
        if (ctrl_if.center) begin
          state_d = S_ADJ;
          field_d = 2'd0;
        end else if (!ctrl_if.left && !ctrl_if.right) begin
          if (ctrl_if.up)        alarm_en_d = 1'b1;
          else if (ctrl_if.down) alarm_en_d = 1'b0;
        end
        // A match wins the state even when a button is accepted in the same cycle.
        if (alarm_match) state_d = S_RING;
      end
      S_ADJ: begin
        if (ctrl_if.center) begin
          state_d = S_RUN;
        end else if (ctrl_if.left) begin
          field_d = field_q - 2'd1;
        end else if (ctrl_if.right) begin
          field_d = field_q + 2'd1;
        end else if (ctrl_if.up) begin
          case (field_q)
            2'd0:    hr_inc_d    = 1'b1;
            2'd1:    min_inc_d   = 1'b1;
            2'd2:    alarm_hr_d  = (alarm_hr_q == 5'd23) ? 5'd0 : alarm_hr_q + 5'd1;
            default: alarm_min_d = (alarm_min_q == 6'd59) ? 6'd0 : alarm_min_q + 6'd1;
          endcase
        end else if (ctrl_if.down) begin
          case (field_q)
            2'd0:    hr_dec_d    = 1'b1;
            2'd1:    min_dec_d   = 1'b1;
            2'd2:    alarm_hr_d  = (alarm_hr_q == 5'd0) ? 5'd23 : alarm_hr_q - 5'd1;
            default: alarm_min_d = (alarm_min_q == 6'd0) ? 6'd59 : alarm_min_q - 6'd1;
          endcase
        end
      end
      S_RING: begin
        if (any_btn || (ctrl_if.cur_min != alarm_min_q)) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase

    adjust_d  = (state_d == S_ADJ);
    ringing_d = (state_d == S_RING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      field_q     <= 2'd0;
      alarm_hr_q  <= 5'(ALARM_HR_RST);
      alarm_min_q <= 6'(ALARM_MIN_RST);
      alarm_en_q  <= 1'b0;
      adjust_q    <= 1'b0;
      ringing_q   <= 1'b0;
      hr_inc_q    <= 1'b0;
      hr_dec_q    <= 1'b0;
      min_inc_q   <= 1'b0;
      min_dec_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      field_q     <= field_d;
      alarm_hr_q  <= alarm_hr_d;
      alarm_min_q <= alarm_min_d;
      alarm_en_q  <= alarm_en_d;
      adjust_q    <= adjust_d;
      ringing_q   <= ringing_d;
      hr_inc_q    <= hr_inc_d;
      hr_dec_q    <= hr_dec_d;
      min_inc_q   <= min_inc_d;
      min_dec_q   <= min_dec_d;
    end
  end

  assign ctrl_if.adjust    = adjust_q;
  assign ctrl_if.field     = field_q;
  assign ctrl_if.hr_inc    = hr_inc_q;
  assign ctrl_if.hr_dec    = hr_dec_q;
  assign ctrl_if.min_inc   = min_inc_q;
  assign ctrl_if.min_dec   = min_dec_q;
  assign ctrl_if.alarm_hr  = alarm_hr_q;
  assign ctrl_if.alarm_min = alarm_min_q;
  assign ctrl_if.alarm_en  = alarm_en_q;
  assign ctrl_if.ringing   = ringing_q;

endmodule

// File: doc/alarm_clock_ctrl.md
# alarm_clock_ctrl

Mode controller for the digital alarm clock. It sits directly downstream of the debounced button block and consumes its one-cycle `up`, `down`, `left`, `right` and `center` pulses. It sequences the clock between run, adjust and ringing modes, holds the alarm time, and issues increment/decrement strobes to the timekeeping counters. It also raises the alarm when the running time matches the stored alarm time.

## Interface
- `ALARM_HR_RST`, default 0: alarm hour loaded on reset (0..23).
- `ALARM_MIN_RST`, default 0: alarm minute loaded on reset (0..59).

Ports:
- `clk`  in  1  system clock; the single clock for the block.
- `rst`  in  1  reset, synchronous, active-high.
- `up`, `down`, `left`, `right`, `center`  in  1 each  single-cycle button pulses from the button block.
- `cur_hr`  in  5  current time hour, 0..23.
- `cur_min`  in  6  current time minute, 0..59.
- `cur_sec`  in  6  current time second, 0..59.
- `adjust`  out  1  high in ADJ state.
- `field`  out  2  selected field: 0 time hour, 1 time minute, 2 alarm hour, 3 alarm minute.
- `hr_inc`, `hr_dec`, `min_inc`, `min_dec`  out  1 each  one-cycle strobes to the time counters.
- `alarm_hr`  out  5  stored alarm hour.
- `alarm_min`  out  6  stored alarm minute.
- `alarm_en`  out  1  alarm armed.
- `ringing`  out  1  high in RING state.

## Operation
- **States:** RUN, ADJ, RING. All outputs are registered.
- **Reset values:**
  - state = RUN, `field` = 0, `alarm_en` = 0.
  - `alarm_hr` = `ALARM_HR_RST`, `alarm_min` = `ALARM_MIN_RST`.
  - All strobes, `adjust` and `ringing` = 0.
- **Button priority:** at most one button is acted on per cycle. Priority order is `center` > `left` > `right` > `up` > `down`; lower-priority pulses in the same cycle are discarded.
- **RUN:**
  - `center`: go to ADJ, `field` = 0.
  - `up`: `alarm_en` = 1.
  - `down`: `alarm_en` = 0.
  - `left`/`right`: ignored.
  - Alarm match: if `alarm_en`=1 and `cur_hr`==`alarm_hr` and `cur_min`==`alarm_min` and `cur_sec`==0, go to RING. A match in the same cycle as an accepted button is still taken; the button action also applies.
- **ADJ:**
  - `right`: `field` = `field`+1 mod 4.
  - `left`: `field` = `field`-1 mod 4.
  - `up` on field 0 → `hr_inc`; on field 1 → `min_inc`; on field 2 → `alarm_hr`+1, wrapping 23→0; on field 3 → `alarm_min`+1, wrapping 59→0.
  - `down` gives the mirror of `up`: `hr_dec`, `min_dec`, and `alarm_hr` −1 wrapping 0→23, `alarm_min` −1 wrapping 0→59.
  - `center`: go to RUN. `field` holds its value.
  - Alarm match is ignored in ADJ; no ringing while adjusting.
- **RING:**
  - Any button pulse goes to RUN. The press is consumed and has no other effect; `alarm_en` is unchanged.
  - If `cur_min` != `alarm_min`, the alarm auto-stops and goes to RUN.
  - No re-trigger occurs in the same minute, because the match requires `cur_sec`==0.
- **Arithmetic:** alarm registers use explicit compare-and-wrap, not power-of-two overflow. Out-of-range reset parameters are not supported.
- **Time counter strobes:** the block never writes the time counters directly. Wrap-around of the time counters is the timekeeper's responsibility.

## Timing
- **Latency:** a button pulse in cycle N produces its register update or strobe in cycle N+1. A strobe is exactly one cycle wide.
- **Back-to-back pulses:** pulses in consecutive cycles are each honoured; there is no lockout.
- **State outputs:** `adjust` and `ringing` change in the cycle after the transition-causing event.
- **Alarm match:** a match sampled in cycle N raises `ringing` in N+1.
- **Reset mid-operation:** `rst` asserted in any state gives reset values in the next cycle. Strobes pending in that cycle are suppressed, and button pulses coincident with `rst` are ignored.

## Test plan
- **Reset:** assert `rst` from ADJ with `field`=2 and `alarm_hr`=7 → next cycle state RUN, `field`=0, `alarm_hr`=`ALARM_HR_RST`, all strobes 0.
- **Field wrap:** from reset, `center` then `left` → `adjust`=1, `field`=3; then `right` ×2 → `field`=1; then `up` → `min_inc` high for exactly one cycle, one cycle after the pulse.
- **Alarm register wrap:** ADJ, field 2, `alarm_hr`=23, `up` → `alarm_hr`=0; field 3, `alarm_min`=0, `down` → `alarm_min`=59.
- **Alarm trigger and silence:** `alarm_en`=1, alarm 06:30, drive `cur_hr`=6, `cur_min`=30, `cur_sec`=0 → `ringing`=1 next cycle; pulse `down` → state RUN with `alarm_en` still 1; hold the time at 06:30 with `cur_sec` 1..59 → no re-ring.
- **Auto-stop:** while ringing, `cur_min` → 31 → `ringing`=0 next cycle.
- **Simultaneous pulses:** in ADJ, `center`+`up` in the same cycle → go to RUN with no `hr_inc`. In RUN, `left`+`up` in the same cycle → the pulses are discarded and `alarm_en` is unchanged, because `left` wins priority and `left` is ignored in RUN.
